// File: rtl/membus_pkg.sv
// membus_pkg: shared memory-bus arbiter types and constants
package membus_pkg;
  localparam int WRITE_BIT = 12;
  localparam int BEATS = 8;
  typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick favouring the port that did not win last
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);
  assign grant = &req ? ~last_grant : req[1];
  assign valid = |req;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of the memory bus between icache (0) and dcache (1)
module mem_bus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH = 13,
  parameter int WRITE_BIT = membus_pkg::WRITE_BIT,
  parameter int BEATS = membus_pkg::BEATS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      c0_bus_reqcyc,
  output logic                      c0_bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] c0_bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  c0_bus_reqtag,
  output logic                      c0_bus_respcyc,
  input  logic                      c0_bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] c0_bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  c0_bus_resptag,
  input  logic                      c1_bus_reqcyc,
  output logic                      c1_bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] c1_bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  c1_bus_reqtag,
  output logic                      c1_bus_respcyc,
  input  logic                      c1_bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] c1_bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  c1_bus_resptag,
  output logic                      m_bus_reqcyc,
  input  logic                      m_bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] m_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  m_bus_reqtag,
  input  logic                      m_bus_respcyc,
  output logic                      m_bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] m_bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  m_bus_resptag
);
  import membus_pkg::*;
  state_t state;
  logic owner, last_grant, is_write, gnt, gnt_valid;
  logic [2:0] beat;
  logic req_phase, resp_phase, own_reqcyc, own_respack, req_hs, resp_hs, last_beat;
  logic [BUS_DATA_WIDTH-1:0] own_req;
  logic [BUS_TAG_WIDTH-1:0] own_reqtag;
  rr_arb2 u_arb (
    .req({c1_bus_reqcyc, c0_bus_reqcyc}),
    .last_grant(last_grant),
    .grant(gnt),
    .valid(gnt_valid)
  );
  assign own_reqcyc = owner ? c1_bus_reqcyc : c0_bus_reqcyc;
  assign own_req = owner ? c1_bus_req : c0_bus_req;
  assign own_reqtag = owner ? c1_bus_reqtag : c0_bus_reqtag;
  assign own_respack = owner ? c1_bus_respack : c0_bus_respack;
  assign req_phase = state == ADDR || (state == WDATA && is_write);
  assign resp_phase = state == RDATA;
  assign m_bus_reqcyc = req_phase && own_reqcyc;
  assign m_bus_req = req_phase ? own_req : '0;
  assign m_bus_reqtag = req_phase ? own_reqtag : '0;
  assign c0_bus_reqack = req_phase && !owner && m_bus_reqack;
  assign c1_bus_reqack = req_phase && owner && m_bus_reqack;
  assign m_bus_respack = resp_phase && own_respack;
  assign c0_bus_respcyc = resp_phase && !owner && m_bus_respcyc;
  assign c1_bus_respcyc = resp_phase && owner && m_bus_respcyc;
  assign c0_bus_resp = (resp_phase && !owner) ? m_bus_resp : '0;
  assign c1_bus_resp = (resp_phase && owner) ? m_bus_resp : '0;
  assign c0_bus_resptag = (resp_phase && !owner) ? m_bus_resptag : '0;
  assign c1_bus_resptag = (resp_phase && owner) ? m_bus_resptag : '0;
  assign req_hs = m_bus_reqcyc && m_bus_reqack;
  assign resp_hs = m_bus_respcyc && m_bus_respack;
  assign last_beat = beat == 3'(BEATS - 1);
  // A stalled handshake simply holds state; there is no timeout or preemption
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= 1'b0;
      last_grant <= 1'b1;
      is_write <= 1'b0;
      beat <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_valid) begin
          state <= ADDR;
          owner <= gnt;
        end
        ADDR: if (req_hs) begin
          is_write <= own_reqtag[WRITE_BIT];
          beat <= '0;
          state <= own_reqtag[WRITE_BIT] ? WDATA : RDATA;
        end
        WDATA: if (req_hs) begin
          beat <= last_beat ? '0 : beat + 3'd1;
          if (last_beat) begin
            state <= IDLE;
            last_grant <= owner;
          end
        end
        RDATA: if (resp_hs) begin
          beat <= last_beat ? '0 : beat + 3'd1;
          if (last_beat) begin
            state <= IDLE;
            last_grant <= owner;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: vector table, directed corner sequences and random run against a transaction model
module tb_mem_bus_arbiter;
  localparam int DW = 64, TW = 13, WB = 12, NB = 8;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  logic [1:0] reqcyc, reqack, respcyc, respack;
  logic [DW-1:0] req [2], resp [2];
  logic [TW-1:0] reqtag [2], resptag [2];
  logic m_reqcyc, m_reqack, m_respcyc, m_respack;
  logic [DW-1:0] m_req, m_resp;
  logic [TW-1:0] m_reqtag, m_resptag;
  int errors = 0, checks = 0;
  int ph = 0, done = 0;
  bit own = 0, last = 1;

  mem_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .c0_bus_reqcyc(reqcyc[0]), .c0_bus_reqack(reqack[0]), .c0_bus_req(req[0]), .c0_bus_reqtag(reqtag[0]),
    .c0_bus_respcyc(respcyc[0]), .c0_bus_respack(respack[0]), .c0_bus_resp(resp[0]), .c0_bus_resptag(resptag[0]),
    .c1_bus_reqcyc(reqcyc[1]), .c1_bus_reqack(reqack[1]), .c1_bus_req(req[1]), .c1_bus_reqtag(reqtag[1]),
    .c1_bus_respcyc(respcyc[1]), .c1_bus_respack(respack[1]), .c1_bus_resp(resp[1]), .c1_bus_resptag(resptag[1]),
    .m_bus_reqcyc(m_reqcyc), .m_bus_reqack(m_reqack), .m_bus_req(m_req), .m_bus_reqtag(m_reqtag),
    .m_bus_respcyc(m_respcyc), .m_bus_respack(m_respack), .m_bus_resp(m_resp), .m_bus_resptag(m_resptag)
  );

  typedef struct {
    logic [1:0] cyc; logic mack, mresp; logic [1:0] rack;
    logic mreqcyc; logic [1:0] ack; logic mrespack; logic [1:0] rcyc;
  } vec_t;
  vec_t tbl [15];

  function automatic vec_t mk(logic [1:0] cyc, logic mack, logic mresp, logic [1:0] rack,
                              logic mreqcyc, logic [1:0] ack, logic mrespack, logic [1:0] rcyc);
    mk = '{cyc, mack, mresp, rack, mreqcyc, ack, mrespack, rcyc};
  endfunction

  task automatic chk(string name, logic [511:0] got, logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Expected outputs follow from who owns the bus and which phase of the line transfer it is in
  task automatic check_model();
    logic rq, rs, e_mreqcyc, e_mrespack;
    logic [1:0] e_ack, e_rcyc;
    logic [DW-1:0] e_mreq, e_resp [2];
    logic [TW-1:0] e_mtag, e_rtag [2];
    rq = ph == 1 || ph == 2;
    rs = ph == 3;
    e_mreqcyc = rq && reqcyc[own];
    e_mreq = rq ? req[own] : '0;
    e_mtag = rq ? reqtag[own] : '0;
    e_ack = '0;
    if (rq) e_ack[own] = m_reqack;
    e_mrespack = rs && respack[own];
    e_rcyc = '0;
    e_resp[0] = '0; e_resp[1] = '0; e_rtag[0] = '0; e_rtag[1] = '0;
    if (rs) begin
      e_rcyc[own] = m_respcyc;
      e_resp[own] = m_resp;
      e_rtag[own] = m_resptag;
    end
    chk("model", {m_reqcyc, m_req, m_reqtag, reqack, m_respack, respcyc, resp[0], resp[1], resptag[0], resptag[1]},
        {e_mreqcyc, e_mreq, e_mtag, e_ack, e_mrespack, e_rcyc, e_resp[0], e_resp[1], e_rtag[0], e_rtag[1]});
  endtask

  task automatic model_edge();
    if (reset) begin
      ph = 0; own = 0; last = 1; done = 0;
    end else case (ph)
      0: if (|reqcyc) begin own = (&reqcyc) ? !last : reqcyc[1]; ph = 1; end
      1: if (reqcyc[own] && m_reqack) begin ph = reqtag[own][WB] ? 2 : 3; done = 0; end
      2: if (reqcyc[own] && m_reqack) begin done++; if (done == NB) begin ph = 0; last = own; end end
      default: if (m_respcyc && respack[own]) begin done++; if (done == NB) begin ph = 0; last = own; end end
    endcase
  endtask

  task automatic tick();
    #1 check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic quiet();
    reqcyc = 0; respack = 0; m_reqack = 0; m_respcyc = 0;
    req[0] = 0; req[1] = 0; reqtag[0] = 0; reqtag[1] = 0; m_resp = 0; m_resptag = 0;
  endtask

  task automatic do_reset();
    quiet();
    reset = 1;
    tick();
    reset = 0;
  endtask

  initial begin
    quiet();
    @(posedge clk);
    model_edge();
    #1;
    do_reset();
    tick();
    // table: both request on the first cycle after reset, c0 read, then c1 wins the next round
    tbl[0] = mk(2'b11, 1, 1, 2'b11, 0, 2'b00, 0, 2'b00);
    tbl[1] = mk(2'b11, 0, 0, 2'b00, 1, 2'b00, 0, 2'b00);
    tbl[2] = mk(2'b11, 1, 0, 2'b00, 1, 2'b01, 0, 2'b00);
    tbl[3] = mk(2'b10, 1, 1, 2'b00, 0, 2'b00, 0, 2'b01);
    tbl[4] = mk(2'b10, 1, 1, 2'b10, 0, 2'b00, 0, 2'b01);
    for (int i = 5; i < 13; i++) tbl[i] = mk(2'b10, 0, 1, 2'b01, 0, 2'b00, 1, 2'b01);
    tbl[13] = mk(2'b10, 1, 0, 2'b00, 0, 2'b00, 0, 2'b00);
    tbl[14] = mk(2'b11, 1, 0, 2'b00, 1, 2'b10, 0, 2'b00);
    req[0] = 64'h1000; req[1] = 64'h2000;
    for (int i = 0; i < 15; i++) begin
      reqcyc = tbl[i].cyc; m_reqack = tbl[i].mack; m_respcyc = tbl[i].mresp; respack = tbl[i].rack;
      m_resp = 64'hA0 + 64'(i);
      #1 chk($sformatf("tbl%0d", i), {m_reqcyc, reqack, m_respack, respcyc},
             {tbl[i].mreqcyc, tbl[i].ack, tbl[i].mrespack, tbl[i].rcyc});
      tick();
    end
    // c0 read at 0x1000, responses 0xA0..0xA7, memory response in IDLE gets no ack
    do_reset();
    reqcyc = 2'b01; req[0] = 64'h1000; reqtag[0] = 13'h005;
    tick();
    m_reqack = 1;
    #1 chk("rd_addr", m_req, 64'h1000);
    tick();
    reqcyc = 0; m_reqack = 0;
    for (int i = 0; i < NB; i++) begin
      m_respcyc = 1; m_resp = 64'hA0 + 64'(i); m_resptag = 13'h005; respack = 2'b01;
      if (i == 2) begin
        respack = 0;
        #1 chk("rd_hold_ack", m_respack, 0);
        tick();
        respack = 2'b01;
      end
      #1 chk("rd_resp", {respcyc, resp[0]}, {2'b01, 64'hA0 + 64'(i)});
      tick();
    end
    #1 chk("idle_noack", {m_respack, respcyc}, 0);
    tick();
    // c1 write at 0x2040, memory stalls beat 3 for 5 cycles
    quiet();
    reqcyc = 2'b10; req[1] = 64'h2040; reqtag[1] = 13'h1007;
    tick();
    m_reqack = 1;
    #1 chk("wr_addr", {m_req, m_reqtag}, {64'h2040, 13'h1007});
    tick();
    for (int b = 0; b < NB; b++) begin
      req[1] = 64'h11 * 64'(b + 1);
      if (b == 3) begin
        m_reqack = 0;
        repeat (5) begin
          #1 chk("wr_stall_ack", {reqack, m_req}, {2'b00, 64'h44});
          tick();
        end
        m_reqack = 1;
      end
      m_respcyc = 1;
      #1 chk("wr_data", {reqack, m_req, respcyc, m_respack}, {2'b10, 64'h11 * 64'(b + 1), 3'b000});
      tick();
    end
    #1 chk("wr_idle", {m_reqcyc, reqack}, 0);
    tick();
    // reset during RDATA beat 5
    quiet();
    reqcyc = 2'b01;
    tick();
    m_reqack = 1;
    tick();
    reqcyc = 0; m_reqack = 0; m_respcyc = 1; respack = 2'b11;
    repeat (5) tick();
    reset = 1;
    tick();
    reset = 0;
    #1 chk("rst_outs", {m_reqcyc, reqack, m_respack, respcyc, resp[0]}, 0);
    tick();
    quiet();
    reqcyc = 2'b10; m_reqack = 1;
    tick();
    #1 chk("rst_c1_grant", {m_reqcyc, reqack}, 3'b110);
    tick();
    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset = $urandom_range(0, 199) == 0;
      reqcyc = 2'($urandom);
      respack = 2'($urandom);
      m_reqack = 1'($urandom);
      m_respcyc = 1'($urandom);
      for (int k = 0; k < 2; k++) begin
        req[k] = {$urandom, $urandom};
        reqtag[k] = 13'($urandom);
      end
      m_resp = {$urandom, $urandom};
      m_resptag = 13'($urandom);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
